// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// load_store_unit_pkg : shared types, op codes and helpers for the LSU
// Revision : 1.0
// ============================================================================
package load_store_unit_pkg;

    localparam int WORD_LEN = 32;

    localparam logic [2:0] LSU_LB  = 3'd0;
    localparam logic [2:0] LSU_LBU = 3'd1;
    localparam logic [2:0] LSU_LH  = 3'd2;
    localparam logic [2:0] LSU_LHU = 3'd3;
    localparam logic [2:0] LSU_LW  = 3'd4;
    localparam logic [2:0] LSU_SB  = 3'd5;
    localparam logic [2:0] LSU_SH  = 3'd6;
    localparam logic [2:0] LSU_SW  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: bad = lane[0];
            LSU_LW, LSU_SW:          bad = (lane != 2'b00);
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        return (op <= LSU_LW);
    endfunction

    // Replace the addressed byte/halfword lane of a memory word with store data.
    function automatic logic [WORD_LEN-1:0] merge_store(
        input logic [WORD_LEN-1:0] word,
        input logic [WORD_LEN-1:0] wdata,
        input logic [1:0]          lane,
        input logic [2:0]          op
    );
        logic [WORD_LEN-1:0] res;
        res = word;
        if (op == LSU_SB) begin
            res[{lane, 3'b000} +: 8] = wdata[7:0];
        end else begin
            res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
// load_align : extracts the addressed lane of a loaded word and extends it
// Revision : 1.0
// ============================================================================
module load_align
    import load_store_unit_pkg::*;
#(
    parameter int WORD_LEN = load_store_unit_pkg::WORD_LEN
) (
    input  logic [WORD_LEN-1:0] word,
    input  logic [1:0]          lane,
    input  logic [2:0]          op,
    output logic [WORD_LEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = word[{lane[1], 4'b0000} +: 16];
        case (op)
            LSU_LB:  result = {{(WORD_LEN-8){byte_sel[7]}}, byte_sel};
            LSU_LBU: result = {{(WORD_LEN-8){1'b0}}, byte_sel};
            LSU_LH:  result = {{(WORD_LEN-16){half_sel[15]}}, half_sel};
            LSU_LHU: result = {{(WORD_LEN-16){1'b0}}, half_sel};
            LSU_LW:  result = word;
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : MEM-stage front end; sub-word stores via read-modify-write
// Revision : 1.0
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WORD_LEN = load_store_unit_pkg::WORD_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_misalign,
    output logic                mem_we,
    output logic [WORD_LEN-1:0] mem_a,
    output logic [WORD_LEN-1:0] mem_wd,
    input  logic [WORD_LEN-1:0] mem_rd
);

    lsu_state_t          state;
    logic [2:0]          op_q;
    logic [WORD_LEN-1:0] addr_q;
    logic [WORD_LEN-1:0] wdata_q;
    logic [WORD_LEN-1:0] merge_buf;
    logic [WORD_LEN-1:0] load_data;
    logic                mem_active;

    load_align #(.WORD_LEN(WORD_LEN)) u_load_align (
        .word   (mem_rd),
        .lane   (addr_q[1:0]),
        .op     (op_q),
        .result (load_data)
    );

    assign mem_active = (state == ST_READ) || (state == ST_RMW_READ) || (state == ST_WRITE);
    assign req_ready  = rst_n && (state == ST_IDLE);
    // Gated by rst_n so a WRITE interrupted by reset never commits.
    assign mem_we     = rst_n && (state == ST_WRITE);
    assign mem_a      = mem_active ? {addr_q[WORD_LEN-1:2], 2'b00} : '0;
    assign mem_wd     = (state == ST_WRITE) ? ((op_q == LSU_SW) ? wdata_q : merge_buf) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
            merge_buf     <= '0;
            op_q          <= 3'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (is_misaligned(req_op, req_addr[1:0])) begin
                            state         <= ST_DONE;
                            resp_valid    <= 1'b1;
                            resp_rdata    <= '0;
                            resp_misalign <= 1'b1;
                        end else if (is_load(req_op)) begin
                            state <= ST_READ;
                        end else if (req_op == LSU_SW) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_RMW_READ;
                        end
                    end
                end
                ST_READ: begin
                    state         <= ST_DONE;
                    resp_valid    <= 1'b1;
                    resp_rdata    <= load_data;
                    resp_misalign <= 1'b0;
                end
                ST_RMW_READ: begin
                    state     <= ST_WRITE;
                    merge_buf <= merge_store(mem_rd, wdata_q, addr_q[1:0], op_q);
                end
                ST_WRITE: begin
                    state         <= ST_DONE;
                    resp_valid    <= 1'b1;
                    resp_rdata    <= '0;
                    resp_misalign <= 1'b0;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
